booth_multiplier_32: RTL

//   Iterative radix-2 Booth signed multiplier for the ALU's multiply path.

---
 rtl/booth_multiplier_32_if.sv | 24 ++
 rtl/booth_multiplier_32.sv | 125 ++++++++++++
 2 files changed

// File: rtl/booth_multiplier_32_if.sv
// Handshake and operand/result bundle for the iterative Booth multiplier.
// The requester drives start and the operands; the multiplier returns
// status and the product.
interface booth_multiplier_32_if #(
    parameter int WIDTH = 32
);
    logic                    start;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] result;
    logic                    ovf;

    modport master (
        output start, A, B,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, A, B,
        output busy, done, result, ovf
    );
endinterface

// File: rtl/booth_multiplier_32.sv
// Iterative radix-2 Booth signed multiplier.
// One add/subtract/pass of the multiplicand per clock over WIDTH clocks, then
// a one-cycle done pulse with the low WIDTH product bits and a signed-overflow
// flag. A new operation may be accepted in the done cycle.
module booth_multiplier_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic                 clock,
    input logic                 reset_n,
    booth_multiplier_32_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Multiplicand is one bit wider so that negating the most negative value fits.
    logic signed [WIDTH:0]       m_q;
    // {upper accumulator (WIDTH+1), multiplier (WIDTH), Booth guard bit}
    logic signed [2*WIDTH+1:0]   p_q;
    logic        [CNT_W-1:0]     cnt_q;
    logic signed [WIDTH-1:0]     result_q;
    logic                        ovf_q;

    logic                        accept;
    logic                        last_iter;
    logic                        busy_c;
    logic                        done_c;

    logic signed [WIDTH:0]       upper;
    logic signed [WIDTH:0]       addend;
    logic                        cin;
    logic signed [WIDTH:0]       sum;
    logic signed [2*WIDTH+1:0]   p_step;
    logic        [2*WIDTH-1:0]   prod;
    logic                        ovf_step;

    assign accept    = bus.start && (state_q == IDLE || state_q == DONE);
    assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; start is ignored while running.
    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = bus.start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One Booth step: pick +M, -M (as ~M + 1) or nothing from the guard pair,
    // add into the upper half, then shift the whole register right arithmetically.
    always_comb begin
        upper  = p_q[2*WIDTH+1:WIDTH+1];
        addend = '0;
        cin    = 1'b0;
        case (p_q[1:0])
            2'b01: addend = m_q;
            2'b10: begin
                addend = ~m_q;
                cin    = 1'b1;
            end
            default: addend = '0;
        endcase
        sum      = upper + addend + $signed({{WIDTH{1'b0}}, cin});
        p_step   = $signed({sum, p_q[WIDTH:0]}) >>> 1;
        prod     = p_step[2*WIDTH:1];
        ovf_step = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
    end

    // Operand capture on accept, iteration while running, result capture on the last step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                m_q   <= {bus.A[WIDTH-1], bus.A};
                p_q   <= {{(WIDTH+1){1'b0}}, bus.B, 1'b0};
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                p_q   <= p_step;
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_iter) begin
                result_q <= prod[WIDTH-1:0];
                ovf_q    <= ovf_step;
            end
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

endmodule
